// File: rtl/plot_sink_pkg.sv
// Shared types and constants for the plot_sink pixel-to-framebuffer path.
package plot_sink_pkg;

    localparam int SCR_W_DEF = 160;
    localparam int SCR_H_DEF = 120;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int COL_W     = 9;
    localparam int ADDR_W    = 15;
    localparam int ENTRY_W   = ADDR_W + COL_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Linear framebuffer address; in-range coordinates never exceed 15 bits.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y,
                                                   input int scr_w);
        int a;
        a = int'(x) + scr_w * int'(y);
        return a[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/plot_sink_if.sv
// Pixel request / framebuffer write bundle for plot_sink.
interface plot_sink_if
    import plot_sink_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [X_W-1:0]    iX;
    logic [Y_W-1:0]    iY;
    logic [COL_W-1:0]  iColour;
    logic              iPlot;
    logic              iDone;
    logic              iMemBusy;
    logic              oReady;
    logic [ADDR_W-1:0] oAddr;
    logic [COL_W-1:0]  oData;
    logic              oWren;
    logic              oFrameDone;
    logic              oOverflow;
    logic [CNT_W-1:0]  oCount;

    modport slave (
        input  iX, iY, iColour, iPlot, iDone, iMemBusy,
        output oReady, oAddr, oData, oWren, oFrameDone, oOverflow, oCount
    );

    modport master (
        output iX, iY, iColour, iPlot, iDone, iMemBusy,
        input  oReady, oAddr, oData, oWren, oFrameDone, oOverflow, oCount
    );

endinterface

// File: rtl/plot_fifo.sv
// Synchronous FIFO of {addr, colour} entries; head is read combinationally.
module plot_fifo
    import plot_sink_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       iClock,
    input  logic                       iResetn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [ENTRY_W-1:0]         i_data,
    output logic [ENTRY_W-1:0]         o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge iClock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/plot_sink.sv
// Buffers pixel writes into a framebuffer port and signals when a frame has drained.
//  state    | meaning
//  ST_IDLE  | no frame-done pending
//  ST_DRAIN | waiting for r_remaining pixel writes to be accepted
//  ST_DONE  | oFrameDone pulse cycle
module plot_sink
    import plot_sink_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic     iClock,
    input  logic     iResetn,
    plot_sink_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int REM_W = CNT_W + 1;

    logic               w_in_range;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_load;
    logic               w_wr_acc;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic [REM_W-1:0]   w_snap;

    logic [ADDR_W-1:0]  r_addr;
    logic [COL_W-1:0]   r_data;
    logic               r_wren;
    logic               r_overflow;
    logic               r_frame_done;
    state_t             r_state;
    logic [REM_W-1:0]   r_remaining;

    assign w_in_range  = (int'(bus.iX) < SCR_W) && (int'(bus.iY) < SCR_H);
    assign w_push      = bus.iPlot && !w_full && w_in_range;
    assign w_wr_acc    = r_wren && !bus.iMemBusy;
    assign w_load      = !r_wren || !bus.iMemBusy;
    assign w_pop       = w_load && !w_empty;
    assign w_push_data = {pix_addr(bus.iX, bus.iY, SCR_W), bus.iColour};
    // Everything still owed for this frame, counting this edge's push and write.
    assign w_snap      = REM_W'(w_count) + REM_W'(r_wren) + REM_W'(w_push)
                         - REM_W'(w_wr_acc);

    plot_fifo #(.DEPTH(DEPTH)) u_fifo (
        .iClock  (iClock),
        .iResetn (iResetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Output register: refills from the FIFO head when empty or when its write is taken.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_wren <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_wren <= !w_empty;
            if (!w_empty) begin
                {r_addr, r_data} <= w_head;
            end
        end
    end

    // Sticky flag for in-range pixels lost to a full FIFO.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_overflow <= 1'b0;
        end else if (bus.iPlot && w_full && w_in_range) begin
            r_overflow <= 1'b1;
        end
    end

    // Frame-done tracker; a new iDone always replaces the outstanding count.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.iDone) begin
                r_remaining <= w_snap;
                if (w_snap == '0) begin
                    r_state      <= ST_DONE;
                    r_frame_done <= 1'b1;
                end else begin
                    r_state <= ST_DRAIN;
                end
            end else begin
                case (r_state)
                    ST_DRAIN: begin
                        if (w_wr_acc) begin
                            r_remaining <= r_remaining - REM_W'(1);
                            if (r_remaining == REM_W'(1)) begin
                                r_state      <= ST_DONE;
                                r_frame_done <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.oReady     = !w_full;
    assign bus.oAddr      = r_addr;
    assign bus.oData      = r_data;
    assign bus.oWren      = r_wren;
    assign bus.oFrameDone = r_frame_done;
    assign bus.oOverflow  = r_overflow;
    assign bus.oCount     = w_count;

endmodule

// File: doc/plot_sink.md
PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 Parameter DEPTH, default 8, pixel FIFO entries (power of two, 2..32).
REQ-002 Parameter SCR_W, default 160, screen width in pixels; SCR_H, default 120, screen height in pixels.
REQ-003 iClock  in  1  sole clock, all logic on rising edge.
REQ-004 iResetn  in  1  reset, synchronous, active-low.
REQ-005 iX  in  8  pixel x; iY  in  7  pixel y; iColour  in  9  colour {R,G,B} 3 bits each.
REQ-006 iPlot  in  1  pixel-write request, sampled every edge.
REQ-007 iDone  in  1  frame-done pulse from drawer.
REQ-008 oReady  out  1  FIFO not full.
REQ-009 oAddr  out  15  framebuffer address; oData  out  9  framebuffer colour; oWren  out  1  write valid.
REQ-010 iMemBusy  in  1  framebuffer stall; a write is accepted on an edge where oWren=1 and iMemBusy=0.
REQ-011 oFrameDone  out  1  one-cycle pulse: every pixel accepted up to and including the iDone cycle has been written.
REQ-012 oOverflow  out  1  sticky: a pixel was dropped because the FIFO was full.
REQ-013 oCount  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-014 Pixel accepted when iPlot=1, oReady=1, iX<SCR_W and iY<SCR_H; out-of-range pixels dropped silently, no flag.
REQ-015 On acceptance, enqueue {addr = iX + SCR_W*iY (15-bit, no truncation for in-range), colour = iColour}.
REQ-016 iPlot=1 with oReady=0 and in-range: pixel dropped, oOverflow set to 1 until reset.
REQ-017 Full FIFO with pop and push on the same edge: oReady is still 0; push dropped and flagged per REQ-016.
REQ-018 Output register (oAddr/oData/oWren) loads FIFO head when it is empty or its write is accepted; oWren=0 when no entry is loaded.
REQ-019 oAddr/oData/oWren held stable while oWren=1 and iMemBusy=1.
REQ-020 Latency: with FIFO and output register empty and iMemBusy=0, a pixel sampled at edge N gives oWren=1 from edge N+2.
REQ-021 Throughput: one write per cycle sustained while iMemBusy=0; order strictly FIFO.
REQ-022 FSM states IDLE, DRAIN, DONE; reset to IDLE.
REQ-023 On iDone, snapshot remaining = oCount + output-register valid + (pixel accepted this edge ? 1 : 0), minus 1 if a write is accepted on the same edge.
REQ-024 IDLE: on iDone go to DRAIN; go to DONE instead if the snapshot is 0.
REQ-025 DRAIN: decrement remaining on each accepted write; go to DONE on the edge it reaches 0.
REQ-026 DRAIN: iDone re-snapshots per REQ-023 and supersedes the old count, giving a single oFrameDone.
REQ-027 DONE: oFrameDone=1 for exactly one cycle; next state IDLE, or DRAIN/DONE per REQ-024 if iDone is high.
REQ-028 Pixels accepted after the iDone edge are not counted toward that oFrameDone.

Reset
REQ-029 iResetn=0 at an edge: FIFO empty, output register invalid, FSM IDLE, remaining=0, discarding any in-flight data.
REQ-030 Reset values: oWren=0, oAddr=0, oData=0, oFrameDone=0, oOverflow=0, oCount=0, oReady=1.

Structure
REQ-031 Shared package: SCR_W/SCR_H defaults, colour width 9, address width 15, FSM state encoding.
REQ-032 Sub-module plot_fifo: synchronous FIFO, parameter DEPTH, 24-bit entries, push/pop/full/empty/count.

Verification
REQ-033 Reset, then plot (5,3,0x1C0) with iMemBusy=0 -> oWren=1 at edge N+2, oAddr=485, oData=0x1C0, one cycle.
REQ-034 Plot (160,0) and (0,120) -> no write, oOverflow=0, oCount stays 0.
REQ-035 iMemBusy=1, 10 consecutive plots with DEPTH=8 -> oCount=8, oReady=0, oOverflow=1; release busy -> 9 writes in order, outputs stable during stall.
REQ-036 Three plots, iDone on the third's cycle, then two more plots, busy 0 -> oFrameDone one cycle after the third write is accepted, before the fourth.
REQ-037 iDone with nothing pending -> oFrameDone at next edge; second iDone during DRAIN -> single pulse after the later snapshot drains.
REQ-038 iResetn low one cycle mid-burst -> next edge oWren=0, oCount=0, FSM IDLE, no oFrameDone.
